// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the execute-stage divider.
//   - DIV_DATA_W    : default operand width
//   - ST_*          : divider FSM state encoding (2-bit, legacy-compatible)
//   - ALU_DIV/DIVU  : ALU control codes the decoder uses to derive
//                     start and signed_div for the divider
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  // Divider FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ZERO = 2'b01;
  localparam logic [1:0] ST_BUSY = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // ALU control codes that select the divider
  localparam logic [4:0] ALU_DIV  = 5'b11010;
  localparam logic [4:0] ALU_DIVU = 5'b11011;

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: pipeline <-> divider connection.
//   master : execute-stage pipeline side (drives start/operands, sees result)
//   slave  : divider side
//   start, signed_div, annul : request, DIV vs DIVU, E-stage flush
//   opa, opb                 : dividend / divisor
//   result                   : {HI = remainder, LO = quotient}
//   ready, div_stall         : result-valid pulse, stall request to hazard unit
interface div_unit_if #(parameter int DATA_W = 32);

  logic                  start;
  logic                  signed_div;
  logic                  annul;
  logic [DATA_W-1:0]     opa;
  logic [DATA_W-1:0]     opb;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;
  logic                  div_stall;

  modport master (
    output start, signed_div, annul, opa, opb,
    input  result, ready, div_stall
  );

  modport slave (
    input  start, signed_div, annul, opa, opb,
    output result, ready, div_stall
  );

endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_unit_if slave modport (start/signed_div/annul/opa/opb in,
//              result/ready/div_stall out)
// Signed operations divide magnitudes and fix the signs up on the last step.
// Divide-by-zero takes a short path returning {dividend, all-ones}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [DATA_W-1:0]   rem_r;
  logic [DATA_W-1:0]   quo_r;
  logic [DATA_W-1:0]   div_r;
  logic                neg_q_r;
  logic                neg_r_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*DATA_W-1:0] result_r;
  logic                ready_r;

  logic                sign_a_s;
  logic                sign_b_s;
  logic                opb_zero_s;
  logic                last_step_s;
  logic [DATA_W+1:0]   trial_s;
  logic [DATA_W-1:0]   rem_step_s;
  logic [DATA_W-1:0]   quo_step_s;

  // Conditional two's complement; 0x80000000 stays as its unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_neg(input logic [DATA_W-1:0] v,
                                                input logic neg);
    logic [DATA_W-1:0] r;
    if (neg) begin
      r = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign sign_a_s    = bus.signed_div & bus.opa[DATA_W-1];
  assign sign_b_s    = bus.signed_div & bus.opb[DATA_W-1];
  assign opb_zero_s  = (bus.opb == {DATA_W{1'b0}});
  assign last_step_s = (cnt_r == CNT_W'(DATA_W - 1));

  // One restoring step. The shifted remainder needs DATA_W+1 bits, since
  // 2*rem+1 can exceed DATA_W bits when the divisor is large; the extra MSB
  // of trial_s is the borrow.
  always_comb begin
    trial_s = {1'b0, rem_r, quo_r[DATA_W-1]} - {2'b00, div_r};
    if (trial_s[DATA_W+1]) begin
      rem_step_s = {rem_r[DATA_W-2:0], quo_r[DATA_W-1]};
      quo_step_s = {quo_r[DATA_W-2:0], 1'b0};
    end else begin
      rem_step_s = trial_s[DATA_W-1:0];
      quo_step_s = {quo_r[DATA_W-2:0], 1'b1};
    end
  end

  // Next-state logic; annul overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.annul) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_nxt_s = opb_zero_s ? ST_ZERO : ST_BUSY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: state_nxt_s = last_step_s ? ST_DONE : ST_BUSY;
        ST_ZERO: state_nxt_s = ST_DONE;
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, iteration, result load and ready pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r    <= {DATA_W{1'b0}};
      quo_r    <= {DATA_W{1'b0}};
      div_r    <= {DATA_W{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      result_r <= {(2*DATA_W){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      if (!bus.annul) begin
        case (state_r)
          ST_IDLE: begin
            if (bus.start) begin
              // rem_r carries the raw dividend into the divide-by-zero path.
              rem_r   <= opb_zero_s ? bus.opa : {DATA_W{1'b0}};
              quo_r   <= abs_neg(bus.opa, sign_a_s);
              div_r   <= abs_neg(bus.opb, sign_b_s);
              neg_q_r <= sign_a_s ^ sign_b_s;
              neg_r_r <= sign_a_s;
              cnt_r   <= {CNT_W{1'b0}};
            end
          end
          ST_BUSY: begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_step_s) begin
              result_r <= {abs_neg(rem_step_s, neg_r_r),
                           abs_neg(quo_step_s, neg_q_r)};
              ready_r  <= 1'b1;
            end
          end
          ST_ZERO: begin
            result_r <= {rem_r, {DATA_W{1'b1}}};
            ready_r  <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.result    = result_r;
  assign bus.ready     = ready_r;
  // Released in DONE so the E stage advances in the same cycle ready pulses.
  assign bus.div_stall = bus.start & ~bus.annul & (state_r != ST_DONE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks_cnt = 0;
  int          errors_cnt = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_exp;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division on magnitudes, MIPS divide-by-zero value.
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic        na, nb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    na = sd & a[31];
    nb = sd & b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one operation with start held until ready; check latency, stall
  // length, result and single-cycle ready. Operands are scrambled once BUSY.
  task automatic run_op(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] exp);
    int cyc;
    int stall_cnt;
    bit got;
    sb_q.push_back(exp);
    last_exp = exp;
    bus.start = 1'b1;
    bus.signed_div = sd;
    bus.opa = a;
    bus.opb = b;
    cyc = 0;
    stall_cnt = 0;
    got = 1'b0;
    while (!got && cyc <= 60) begin
      @(negedge clk);
      if (bus.div_stall) stall_cnt++;
      if (bus.ready) begin
        got = 1'b1;
        check_val({tag, "_lat"}, 64'(cyc), 64'(lat));
        check_val({tag, "_res"}, bus.result, sb_q.pop_front());
        check_val({tag, "_stall"}, 64'(stall_cnt), 64'(lat));
      end
      tick;
      if (cyc == 0) begin
        bus.opa = $urandom;
        bus.opb = $urandom;
        bus.signed_div = ~sd;
      end
      cyc++;
    end
    if (!got) begin
      check_val({tag, "_timeout"}, 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
    bus.start = 1'b0;
    @(negedge clk);
    check_val({tag, "_pulse"}, 64'(bus.ready), 64'd0);
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_ready;
    int r1, r2;
    bit first_seen;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    bus.signed_div = 1'b0;
    bus.opa = 32'd0;
    bus.opb = 32'd0;
    last_exp = 64'd0;
    repeat (3) tick;
    @(negedge clk);
    check_val("rst_result", bus.result, 64'd0);
    check_val("rst_ready", 64'(bus.ready), 64'd0);
    check_val("rst_stall", 64'(bus.div_stall), 64'd0);
    tick;
    rst = 1'b0;
    tick;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD});
    run_op("divu_zero", 1'b0, 32'h0000_1234, 32'd0, 2, {32'h0000_1234, 32'hFFFF_FFFF});
    run_op("div_zero", 1'b1, 32'hFFFF_FF00, 32'd0, 2, {32'hFFFF_FF00, 32'hFFFF_FFFF});
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000});
    run_op("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF});
    run_op("divu_bigdiv", 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, {32'hFFFF_FFFE, 32'd0});

    // Annul in BUSY cycle 10: no ready afterwards, result untouched.
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa = 32'd1000;
    bus.opb = 32'd3;
    repeat (10) tick;
    bus.annul = 1'b1;
    @(negedge clk);
    check_val("annul_stall", 64'(bus.div_stall), 64'd0);
    tick;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    n_ready = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) n_ready++;
      tick;
    end
    check_val("annul_no_ready", 64'(n_ready), 64'd0);
    check_val("annul_result", bus.result, last_exp);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});

    // Reset in BUSY cycle 5 clears every output.
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa = 32'h1234_5678;
    bus.opb = 32'd3;
    repeat (5) tick;
    rst = 1'b1;
    bus.start = 1'b0;
    tick;
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_result", bus.result, 64'd0);
    check_val("midrst_ready", 64'(bus.ready), 64'd0);
    check_val("midrst_stall", 64'(bus.div_stall), 64'd0);
    tick;

    // Back-to-back with start held: DONE, one IDLE, 32 BUSY, DONE -> 34 apart.
    sb_q.push_back({32'd0, 32'd10});
    sb_q.push_back({32'd1, 32'd4});
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa = 32'd50;
    bus.opb = 32'd5;
    n_ready = 0;
    r1 = -1;
    r2 = -1;
    for (int cyc = 0; cyc < 120 && n_ready < 2; cyc++) begin
      @(negedge clk);
      first_seen = 1'b0;
      if (bus.ready) begin
        check_val("b2b_res", bus.result, sb_q.pop_front());
        if (n_ready == 0) begin
          r1 = cyc;
          first_seen = 1'b1;
        end else begin
          r2 = cyc;
        end
        n_ready++;
      end
      tick;
      if (first_seen) begin
        bus.opa = 32'd17;
        bus.opb = 32'd4;
      end
    end
    bus.start = 1'b0;
    check_val("b2b_count", 64'(n_ready), 64'd2);
    check_val("b2b_first_lat", 64'(r1), 64'd33);
    check_val("b2b_gap", 64'(r2 - r1), 64'd34);
    tick;

    // Randomised operations against the reference model.
    for (int i = 0; i < 10; i++) begin
      logic        sd;
      logic [31:0] a, b;
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op("rand", sd, a, b, (b == 32'd0) ? 2 : 33, model(sd, a, b));
    end

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
